// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised processor register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

    // Default geometry, shared with the processor top so both agree.
    localparam int REGFILE_WIDTH = 16;
    localparam int REGFILE_DEPTH = 8;

    // Bulk-clear sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks a pointer over every register, one per cycle.
// Latency: clear_busy rises one cycle after clear_req; DEPTH busy cycles, then a one-cycle clear_done.
// Backpressure: none; clear_req is only looked at in IDLE and is ignored while CLEAR/DONE.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH = REGFILE_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_req,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    // Last register index; the walk stops here so the pointer never wraps.
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    clr_state_t    state;
    logic [AW-1:0] ptr;

    // Sequencer state, pointer and registered handshake outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clear_done <= 1'b0;
                    if (clear_req) begin
                        state      <= CLEAR;
                        ptr        <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST_PTR) begin
                        state      <= DONE;
                        ptr        <= '0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    clear_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    ptr        <= '0;
                    clear_busy <= 1'b0;
                    clear_done <= 1'b0;
                end
            endcase
        end
    end

    // The storage array zeroes reg[ptr] on every CLEAR cycle.
    always_comb begin
        clr_we   = (state == CLEAR);
        clr_addr = ptr;
    end

endmodule : regfile_clear_seq

// File: rtl/regfile_param.sv
// WIDTH x DEPTH register file: 2 async read ports, 1 sync write port, bulk clear, dropped-write flag.
// Latency: reads combinational; writes visible next cycle (same cycle on A/B with REGFILE_BYPASS_EN).
// Backpressure: none; writes during a clear, to addresses >= DEPTH or to a hardwired zero reg are dropped and flagged.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = REGFILE_WIDTH,
    parameter  int DEPTH    = REGFILE_DEPTH,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [AW-1:0]          SA,
    input  logic [AW-1:0]          SB,
    output logic [WIDTH-1:0]       A,
    output logic [WIDTH-1:0]       B,
    input  logic [WIDTH-1:0]       D,
    input  logic [AW-1:0]          DA,
    input  logic                   W,
    input  logic                   clear_req,
    output logic                   clear_busy,
    output logic                   clear_done,
    output logic                   write_drop,
    output logic [WIDTH*DEPTH-1:0] regs
);

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             wr_eff;
    logic             sa_ok;
    logic             sb_ok;
    logic             da_ok;

    regfile_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr)
    );

    // Address qualification: out-of-range and hardwired-zero addresses never hit storage.
    always_comb begin
        sa_ok  = ({1'b0, SA} < DEPTH_W) && !((ZERO_REG != 0) && (SA == '0));
        sb_ok  = ({1'b0, SB} < DEPTH_W) && !((ZERO_REG != 0) && (SB == '0));
        da_ok  = ({1'b0, DA} < DEPTH_W) && !((ZERO_REG != 0) && (DA == '0));
        wr_eff = W && !clr_we && da_ok;
    end

    // Storage: the clear pointer and the write port never collide because writes are blocked in CLEAR.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end
            if (wr_eff) begin
                mem[DA] <= D;
            end
        end
    end

    // Flag any requested write that did not land, one cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_drop <= 1'b0;
        end else begin
            write_drop <= W && !wr_eff;
        end
    end

    // Read ports; forwarding only ever uses a write that is actually being stored.
    always_comb begin
        A = '0;
        B = '0;
        if (sa_ok) begin
            A = mem[SA];
        end
        if (sb_ok) begin
            B = mem[SB];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_eff && (SA == DA)) begin
            A = D;
        end
        if (wr_eff && (SB == DA)) begin
            B = D;
        end
`endif
    end

    // Visualization bus always shows the stored contents, never forwarded data.
    for (genvar g = 0; g < DEPTH; g++) begin : g_regs
        assign regs[g*WIDTH +: WIDTH] = mem[g];
    end

endmodule : regfile_param

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  SA, SB, DA;
    logic [15:0] D;
    logic        W, clear_req;

    logic [15:0]  a_o [3];
    logic [15:0]  b_o [3];
    logic         busy_o [3];
    logic         done_o [3];
    logic         drop_o [3];
    logic [127:0] regs0, regs1;
    logic [95:0]  regs2;

    int checks;
    int failures;

    // Reference model: plain arrays + clear progress counter per instance.
    int          dep [3] = '{8, 8, 6};
    bit          zr  [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] mem [3][8];
    int          mclr [3];   // -1 idle, else index of the register being cleared this cycle
    bit          mdone [3];
    bit          mdrop [3];

    always #5 clock = ~clock;

    regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut0 (
        .clock(clock), .reset(reset), .SA(SA), .SB(SB), .A(a_o[0]), .B(b_o[0]),
        .D(D), .DA(DA), .W(W), .clear_req(clear_req), .clear_busy(busy_o[0]),
        .clear_done(done_o[0]), .write_drop(drop_o[0]), .regs(regs0));

    regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) dut1 (
        .clock(clock), .reset(reset), .SA(SA), .SB(SB), .A(a_o[1]), .B(b_o[1]),
        .D(D), .DA(DA), .W(W), .clear_req(clear_req), .clear_busy(busy_o[1]),
        .clear_done(done_o[1]), .write_drop(drop_o[1]), .regs(regs1));

    regfile_param #(.WIDTH(16), .DEPTH(6), .ZERO_REG(0)) dut2 (
        .clock(clock), .reset(reset), .SA(SA), .SB(SB), .A(a_o[2]), .B(b_o[2]),
        .D(D), .DA(DA), .W(W), .clear_req(clear_req), .clear_busy(busy_o[2]),
        .clear_done(done_o[2]), .write_drop(drop_o[2]), .regs(regs2));

    function automatic logic [15:0] dut_reg(int k, int i);
        case (k)
            0:       return regs0[i*16 +: 16];
            1:       return regs1[i*16 +: 16];
            default: return regs2[i*16 +: 16];
        endcase
    endfunction

    function automatic bit eff_now(int k);
        return W && (mclr[k] < 0) && (int'(DA) < dep[k]) && !(zr[k] && DA == 3'd0);
    endfunction

    function automatic logic [15:0] exp_rd(int k, logic [2:0] ad);
        if (int'(ad) >= dep[k] || (zr[k] && ad == 3'd0)) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
        if (eff_now(k) && ad == DA) return D;
`endif
        return mem[k][ad];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) mem[k][i] = 16'h0000;
            mclr[k]  = -1;
            mdone[k] = 1'b0;
            mdrop[k] = 1'b0;
        end
    endtask

    // Advance one clock and apply the rules to the model with the pre-edge inputs.
    task automatic tick();
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit e        = eff_now(k);
                bit was_done = mdone[k];
                mdrop[k] = W && !e;
                if (mclr[k] >= 0) begin
                    mem[k][mclr[k]] = 16'h0000;
                    if (mclr[k] == dep[k] - 1) begin
                        mclr[k]  = -1;
                        mdone[k] = 1'b1;
                    end else begin
                        mclr[k] = mclr[k] + 1;
                    end
                end else if (was_done) begin
                    mdone[k] = 1'b0;
                end else if (clear_req) begin
                    mclr[k] = 0;
                end
                if (e) mem[k][DA] = D;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < dep[k]; i++) begin
                checks++;
                if (dut_reg(k, i) !== 16'h0000) begin
                    failures++;
                    $display("FAIL reset_reg dut%0d r%0d got=%h exp=0000", k, i, dut_reg(k, i));
                end
            end
            checks++;
            if ({busy_o[k], done_o[k], drop_o[k]} !== 3'b000) begin
                failures++;
                $display("FAIL reset_flags dut%0d got busy/done/drop=%b%b%b exp=000", k, busy_o[k], done_o[k], drop_o[k]);
            end
        end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_write_read();
        W = 1'b1; DA = 3'd3; D = 16'hBEEF; SA = 3'd3; SB = 3'd3;
        tick();
        W = 1'b0;
        #1;
        checks++;
        if (a_o[0] !== 16'hBEEF || b_o[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_read_ab got A=%h B=%h exp=BEEF", a_o[0], b_o[0]);
        end
        checks++;
        if (regs0[63:48] !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_read_regs got=%h exp=BEEF", regs0[63:48]);
        end
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                checks++;
                if (dut_reg(0, i) !== 16'h0000) begin
                    failures++;
                    $display("FAIL write_read_other r%0d got=%h exp=0000", i, dut_reg(0, i));
                end
            end
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (a_o[k] !== exp_rd(k, SA)) begin
                failures++;
                $display("FAIL write_read_model dut%0d got=%h exp=%h", k, a_o[k], exp_rd(k, SA));
            end
        end
    endtask

    task automatic test_zero_reg();
        W = 1'b1; DA = 3'd0; D = 16'h1234; SA = 3'd0;
        tick();
        W = 1'b0;
        #1;
        checks++;
        if (a_o[1] !== 16'h0000) begin
            failures++;
            $display("FAIL zero_read got=%h exp=0000", a_o[1]);
        end
        checks++;
        if (drop_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL zero_drop_pulse got=%b exp=1", drop_o[1]);
        end
        checks++;
        if (drop_o[0] !== 1'b0 || a_o[0] !== 16'h1234) begin
            failures++;
            $display("FAIL zero_plain_reg0 got drop=%b A=%h exp drop=0 A=1234", drop_o[0], a_o[0]);
        end
        tick();
        checks++;
        if (drop_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL zero_drop_single got=%b exp=0", drop_o[1]);
        end
    endtask

    task automatic test_bulk_clear();
        int busy_cnt [3];
        int done_cnt [3];
        for (int i = 0; i < 8; i++) begin
            W = 1'b1; DA = 3'(i); D = 16'(i + 1);
            tick();
        end
        W = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 3; k++) begin busy_cnt[k] = 0; done_cnt[k] = 0; end
        for (int cyc = 0; cyc < 16; cyc++) begin
            // Mid-clear write (and a stray request) must be ignored.
            W         = (cyc == 2);
            clear_req = (cyc == 3);
            DA = 3'd7; D = 16'hFFFF;
            #1;
            for (int k = 0; k < 3; k++) begin
                busy_cnt[k] += int'(busy_o[k]);
                done_cnt[k] += int'(done_o[k]);
                checks++;
                if (busy_o[k] !== (mclr[k] >= 0) || done_o[k] !== mdone[k] || drop_o[k] !== mdrop[k]) begin
                    failures++;
                    $display("FAIL clear_flags dut%0d cyc%0d got busy/done/drop=%b%b%b exp=%b%b%b",
                             k, cyc, busy_o[k], done_o[k], drop_o[k], mclr[k] >= 0, mdone[k], mdrop[k]);
                end
                for (int i = 0; i < dep[k]; i++) begin
                    checks++;
                    if (dut_reg(k, i) !== mem[k][i]) begin
                        failures++;
                        $display("FAIL clear_reg dut%0d cyc%0d r%0d got=%h exp=%h", k, cyc, i, dut_reg(k, i), mem[k][i]);
                    end
                end
            end
            tick();
        end
        W = 1'b0; clear_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_cnt[k] != dep[k] || done_cnt[k] != 1) begin
                failures++;
                $display("FAIL clear_length dut%0d got busy=%0d done=%0d exp busy=%0d done=1", k, busy_cnt[k], done_cnt[k], dep[k]);
            end
        end
    endtask

    task automatic test_non_pow2();
        W = 1'b1; DA = 3'd7; D = 16'h5555; SA = 3'd6; SB = 3'd7;
        tick();
        W = 1'b0;
        #1;
        checks++;
        if (drop_o[2] !== 1'b1 || drop_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL np2_drop got d6=%b d8=%b exp d6=1 d8=0", drop_o[2], drop_o[0]);
        end
        checks++;
        if (a_o[2] !== 16'h0000 || b_o[2] !== 16'h0000) begin
            failures++;
            $display("FAIL np2_oob_read got A=%h B=%h exp=0000", a_o[2], b_o[2]);
        end
        checks++;
        if (b_o[0] !== 16'h5555) begin
            failures++;
            $display("FAIL np2_pow2_write got=%h exp=5555", b_o[0]);
        end
        tick();
        checks++;
        if (drop_o[2] !== 1'b0) begin
            failures++;
            $display("FAIL np2_drop_single got=%b exp=0", drop_o[2]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int busy_cnt [3];
        int done_cnt [3];
        for (int i = 1; i < 4; i++) begin
            W = 1'b1; DA = 3'(i); D = 16'hA000 + 16'(i);
            tick();
        end
        W = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_o[k] !== 1'b1) begin
                failures++;
                $display("FAIL midclr_busy dut%0d got=%b exp=1", k, busy_o[k]);
            end
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || dut_reg(k, 3) !== 16'h0000) begin
                failures++;
                $display("FAIL midclr_abort dut%0d got busy=%b done=%b r3=%h exp 0/0/0000", k, busy_o[k], done_o[k], dut_reg(k, 3));
            end
        end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (done_o[k] !== 1'b0 || busy_o[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL midclr_no_done dut%0d got busy=%b done=%b exp 0/0", k, busy_o[k], done_o[k]);
                end
            end
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 3; k++) begin busy_cnt[k] = 0; done_cnt[k] = 0; end
        for (int c = 0; c < 14; c++) begin
            for (int k = 0; k < 3; k++) begin
                busy_cnt[k] += int'(busy_o[k]);
                done_cnt[k] += int'(done_o[k]);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_cnt[k] != dep[k] || done_cnt[k] != 1) begin
                failures++;
                $display("FAIL midclr_rerun dut%0d got busy=%0d done=%0d exp busy=%0d done=1", k, busy_cnt[k], done_cnt[k], dep[k]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_same;
        W = 1'b1; DA = 3'd5; D = 16'h1111;
        tick();
        D = 16'h00AA; SA = 3'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 16'h00AA;
`else
        exp_same = 16'h1111;
`endif
        checks++;
        if (a_o[0] !== exp_same) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h exp=%h", a_o[0], exp_same);
        end
        checks++;
        if (regs0[95:80] !== 16'h1111) begin
            failures++;
            $display("FAIL bypass_regs_stored got=%h exp=1111", regs0[95:80]);
        end
        tick();
        W = 1'b0;
        #1;
        checks++;
        if (a_o[0] !== 16'h00AA) begin
            failures++;
            $display("FAIL bypass_next_cycle got=%h exp=00AA", a_o[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            W         = 1'($urandom_range(0, 1));
            DA        = 3'($urandom_range(0, 7));
            SA        = 3'($urandom_range(0, 7));
            SB        = ($urandom_range(0, 3) == 0) ? DA : 3'($urandom_range(0, 7));
            D         = 16'($urandom);
            clear_req = ($urandom_range(0, 24) == 0);
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (a_o[k] !== exp_rd(k, SA) || b_o[k] !== exp_rd(k, SB)) begin
                    failures++;
                    $display("FAIL rand_read dut%0d n%0d got A=%h B=%h exp A=%h B=%h",
                             k, n, a_o[k], b_o[k], exp_rd(k, SA), exp_rd(k, SB));
                end
                checks++;
                if (busy_o[k] !== (mclr[k] >= 0) || done_o[k] !== mdone[k] || drop_o[k] !== mdrop[k]) begin
                    failures++;
                    $display("FAIL rand_flags dut%0d n%0d got busy/done/drop=%b%b%b exp=%b%b%b",
                             k, n, busy_o[k], done_o[k], drop_o[k], mclr[k] >= 0, mdone[k], mdrop[k]);
                end
                for (int i = 0; i < dep[k]; i++) begin
                    checks++;
                    if (dut_reg(k, i) !== mem[k][i]) begin
                        failures++;
                        $display("FAIL rand_reg dut%0d n%0d r%0d got=%h exp=%h", k, n, i, dut_reg(k, i), mem[k][i]);
                    end
                end
            end
            tick();
        end
        W = 1'b0; clear_req = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; W = 1'b0; clear_req = 1'b0;
        SA = 3'd0; SB = 3'd0; DA = 3'd0; D = 16'h0000;
        model_reset();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bulk_clear();
        test_non_pow2();
        test_reset_mid_clear();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_param

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 8x16 processor register file: WIDTH x DEPTH storage, two asynchronous read ports, one synchronous write port.
- Adds an optional hardwired-zero register 0, a multi-cycle bulk-clear sequencer with busy/done handshake, and dropped-write reporting.
- Sits in the processor datapath between the writeback mux (D/DA/W) and the ALU operand buses (A/B).
- Exports all register contents flattened for visualization.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers; any value >= 2, power of two not required.
- AW, $clog2(DEPTH), derived localparam, address width; not overridable.
- ZERO_REG, 0, when 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- SA  in  AW  A-port read address.
- SB  in  AW  B-port read address.
- A  out  WIDTH  A-port read data.
- B  out  WIDTH  B-port read data.
- D  in  WIDTH  write data.
- DA  in  AW  write address.
- W  in  1  write enable.
- clear_req  in  1  bulk-clear request; sampled only in IDLE.
- clear_busy  out  1  high while the clear sequencer is in CLEAR.
- clear_done  out  1  one-cycle pulse when a clear completes.
- write_drop  out  1  registered pulse, high the cycle after a write is discarded.
- regs  out  WIDTH*DEPTH  flattened contents; register i is at bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (reset=0, asynchronous): all registers 0; FSM to IDLE; clear pointer 0; clear_busy, clear_done and write_drop all 0.
- Reads are combinational: A = reg[SA], B = reg[SB]. An address >= DEPTH reads 0.
- With ZERO_REG=1, address 0 reads 0.
- A write is effective when W=1, state != CLEAR, DA < DEPTH, and not (ZERO_REG=1 and DA=0). reg[DA] <= D at the rising edge.
- Without bypass, a read of a just-written address returns the old value in the write cycle and the new value from the next cycle.
- FSM IDLE:
  - clear_req=1 -> CLEAR with ptr=0.
  - A write presented in the same cycle as clear_req is still performed; the sequencer then clears it.
- FSM CLEAR:
  - Each cycle reg[ptr] <= 0 and ptr <= ptr+1.
  - When ptr = DEPTH-1, go to DONE.
  - The clear takes exactly DEPTH cycles.
  - clear_busy = 1 throughout CLEAR.
  - clear_req is ignored.
  - Reads return current contents, partially cleared.
- FSM DONE: clear_done = 1 for one cycle, then -> IDLE. clear_req is ignored. Writes are accepted again.
- Dropped write: W=1 in a cycle where the write is not effective, for any reason (CLEAR, DA >= DEPTH, or zero register). write_drop = 1 in the following cycle only.
- Reset mid-clear: aborts immediately. All registers 0, IDLE, no clear_done pulse.
- ptr width is AW. It never wraps, because the FSM leaves CLEAR at DEPTH-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If a write is effective this cycle and SA==DA (respectively SB==DA), A (respectively B) = D combinationally.
  - No forwarding for dropped writes.
  - No forwarding for the zero register.
- Undefined: no forwarding; timing as stated in Behaviour.
- regs always shows stored values in both configurations.

Decomposition:
- Package regfile_pkg holds:
  - the FSM state typedef: enum of IDLE, CLEAR, DONE as 2-bit;
  - the default WIDTH/DEPTH constants shared with the processor top.
- Sub-module regfile_clear_seq contains:
  - FSM, pointer, clear_busy and clear_done;
  - outputs clr_we and clr_addr to the storage array.
- Storage, read muxes, bypass and write_drop stay in regfile_param.

Test Plan:
- Reset then write/read: reset low 2 cycles. Write D=16'hBEEF to DA=3, then SA=3, SB=3 -> A=B=16'hBEEF next cycle; regs[63:48]=16'hBEEF; all other registers 0.
- ZERO_REG=1: W=1, DA=0, D=16'h1234 -> SA=0 reads 0; write_drop=1 on the following cycle only.
- Bulk clear: fill regs 0..7 with 1..8, pulse clear_req -> clear_busy high 8 cycles, reg[i]=0 after cycle i+1, clear_done pulses once, then IDLE. A write with W=1 during busy is dropped: register unchanged, write_drop pulses.
- Non-power-of-2: DEPTH=6. Write DA=7 -> ignored and write_drop pulses; SA=6 reads 0; clear takes 6 cycles.
- Reset mid-clear: assert reset on the 3rd CLEAR cycle -> all regs 0, clear_busy=0, no clear_done pulse. A clear_req after release runs a full DEPTH-cycle clear.
- REGFILE_BYPASS_EN: W=1, DA=5, D=16'h00AA, SA=5 in the same cycle -> A=16'h00AA combinationally. Without the macro -> A shows the old value that cycle and 16'h00AA the next.
